// File: rtl/gpio_apb_master_pkg.sv
// Shared definitions for the GPIO APB initiator and the GPIO register slave.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package gpio_apb_defs;

    // GPIO register address map, common to initiator users and the register slave.
    localparam logic [7:0] GPIO_DIR          = 8'h00;
    localparam logic [7:0] GPIO_OUT          = 8'h04;
    localparam logic [7:0] GPIO_IN           = 8'h08;
    localparam logic [7:0] GPIO_INT_MASK     = 8'h0C;
    localparam logic [7:0] GPIO_INT_STATUS   = 8'h10;
    localparam logic [7:0] GPIO_INT_TYPE     = 8'h14;
    localparam logic [7:0] GPIO_INT_POLARITY = 8'h18;
    localparam logic [7:0] GPIO_DEBOUNCE_CFG = 8'h1C;

    // One APB transfer walks IDLE -> SETUP -> ACCESS (n cycles) -> RESP.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // Wait counter must count 0..TIMEOUT-1; keep at least one bit when disabled.
    function automatic int wait_cnt_w(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/gpio_apb_master_if.sv
// APB3 bus between the GPIO initiator (master) and the register slave.
// Latency: none, wires only.
// Backpressure: slave stretches ACCESS by holding PREADY low.
interface gpio_apb_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/gpio_apb_master.sv
// Single-beat valid/ready request -> APB3 transfer -> valid/ready response.
// Latency: 3 cycles accept-to-response with a zero-wait slave, +1 per wait state.
// Backpressure: one transfer in flight; req_ready low until the response is taken.
module gpio_apb_master
    import gpio_apb_defs::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    gpio_apb_master_if.master apb
);

    localparam int CNT_W = wait_cnt_w(TIMEOUT);
    // Count value at which the final allowed ACCESS cycle is being sampled.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    apb_state_e        state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // State and every output register; reset drops the bus and any pending response.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= ST_IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    // Next state: all outputs are registered, so nothing here reaches a port combinationally.
    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;

        case (state_q)
            ST_IDLE: begin
                // req_ready is implied by being in IDLE.
                if (req_valid) begin
                    pwrite_d = req_write;
                    paddr_d  = req_addr;
                    pwdata_d = req_write ? req_wdata : '0;
                    psel_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (apb.PREADY) begin
                    // Completion takes priority over a timeout on the same cycle.
                    rsp_rdata_d   = pwrite_q ? '0 : apb.PRDATA;
                    rsp_err_d     = apb.PSLVERR;
                    rsp_timeout_d = 1'b0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                // rsp_rdata is left holding the last captured value.
                if (rsp_ready) begin
                    rsp_valid_d   = 1'b0;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;

endmodule

// File: tb/tb_gpio_apb_master.sv
// Scoreboard bench for gpio_apb_master with a configurable APB slave model.
// Latency: checks accept-to-PSEL/PENABLE/response edges per transfer.
// Backpressure: exercises slave wait states, PREADY timeout and rsp_ready stalls.
module tb_gpio_apb_master;
    import gpio_apb_defs::*;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              PCLK = 1'b0;
    logic              PRESETn = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    gpio_apb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) apb ();

    gpio_apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) u_dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .apb         (apb)
    );

    always #5 PCLK = ~PCLK;

    // ---------------- APB slave model ----------------
    logic [DATA_W-1:0] mem [8];
    int s_waits = 0;
    bit s_err   = 1'b0;
    bit s_hang  = 1'b0;
    int acc_cnt = 0;

    assign apb.PREADY  = apb.PSEL && apb.PENABLE && !s_hang && (acc_cnt >= s_waits);
    assign apb.PSLVERR = apb.PREADY && s_err;
    assign apb.PRDATA  = mem[apb.PADDR[4:2]];

    // Wait-state counter and register writes of the slave model.
    always @(posedge PCLK) begin
        if (apb.PSEL && apb.PENABLE && !apb.PREADY) acc_cnt <= acc_cnt + 1;
        else                                        acc_cnt <= 0;
        if (apb.PREADY && apb.PWRITE && !s_err) mem[apb.PADDR[4:2]] <= apb.PWDATA;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [DATA_W-1:0] rdata;
        bit                err;
        bit                to;
        int                lat;
        logic [ADDR_W-1:0] addr;
        bit                wr;
        logic [DATA_W-1:0] wdata;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int  cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int  acc_edge, psel_edge, pen_edge, psel_fall, rise_edge, hs_edge;
    bit  psel_prev, pen_prev, rv_prev;
    bit  apb_bad, rsp_bad, hold_bad, expect_b2b;
    logic [ADDR_W-1:0] paddr0;
    logic              pwrite0;
    logic [DATA_W-1:0] pwdata0;
    logic [DATA_W+1:0] rsp0;
    exp_t              me;

    // Track edges relative to acceptance and compare each response at its handshake.
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            psel_prev = 1'b0;
            pen_prev  = 1'b0;
            rv_prev   = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                acc_edge = cyc + 1;
                if (expect_b2b) begin
                    check("b2b_start", 64'(acc_edge), 64'(hs_edge + 1));
                    expect_b2b = 1'b0;
                end
            end
            if (apb.PSEL && !psel_prev) begin
                psel_edge = cyc + 1;
                paddr0    = apb.PADDR;
                pwrite0   = apb.PWRITE;
                pwdata0   = apb.PWDATA;
                apb_bad   = 1'b0;
            end else if (apb.PSEL && ({apb.PADDR, apb.PWRITE, apb.PWDATA} != {paddr0, pwrite0, pwdata0})) begin
                apb_bad = 1'b1;
            end
            if (apb.PENABLE && !pen_prev) pen_edge = cyc + 1;
            if (!apb.PSEL && psel_prev)   psel_fall = cyc + 1;
            if (rsp_valid && !rv_prev) begin
                rise_edge = cyc + 1;
                rsp0      = {rsp_rdata, rsp_err, rsp_timeout};
                rsp_bad   = 1'b0;
                hold_bad  = 1'b0;
            end else if (rsp_valid && ({rsp_rdata, rsp_err, rsp_timeout} != rsp0)) begin
                rsp_bad = 1'b1;
            end
            if (rsp_valid && (apb.PSEL || req_ready)) hold_bad = 1'b1;
            if (rsp_valid && rsp_ready) begin
                hs_edge = cyc + 1;
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 64'(1), 64'(0));
                end else begin
                    me = sb.pop_front();
                    check("rsp_rdata",    64'(rsp_rdata), 64'(me.rdata));
                    check("rsp_err",      64'(rsp_err), 64'(me.err));
                    check("rsp_timeout",  64'(rsp_timeout), 64'(me.to));
                    check("rsp_latency",  64'(rise_edge - acc_edge), 64'(me.lat));
                    check("psel_edge",    64'(psel_edge - acc_edge), 64'(1));
                    check("penable_edge", 64'(pen_edge - acc_edge), 64'(2));
                    check("psel_fall",    64'(psel_fall), 64'(rise_edge));
                    check("paddr",        64'(paddr0), 64'(me.addr));
                    check("pwrite",       64'(pwrite0), 64'(me.wr));
                    check("pwdata",       64'(pwdata0), 64'(me.wdata));
                    check("apb_stable",   64'(apb_bad), 64'(0));
                    check("rsp_stable",   64'(rsp_bad), 64'(0));
                    check("resp_hold",    64'(hold_bad), 64'(0));
                end
            end
            psel_prev = apb.PSEL;
            pen_prev  = apb.PENABLE;
            rv_prev   = rsp_valid;
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input int waits, input bit err, input bit hang,
                         input logic [DATA_W-1:0] exp_rd, input bit exp_err, input bit exp_to,
                         input int lat, input bit keep);
        exp_t e;
        int   n;
        n = 0;
        do begin
            @(posedge PCLK);
            #1;
            n++;
        end while (apb.PSEL && n < 500);
        s_waits = waits;
        s_err   = err;
        s_hang  = hang;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.to    = exp_to;
        e.lat   = lat;
        e.addr  = a;
        e.wr    = wr;
        e.wdata = wr ? d : '0;
        sb.push_back(e);
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge PCLK);
            if (req_ready) break;
            n++;
            if (n > 500) break;
        end
        if (n > 500) begin
            check("accept_bound", 64'(0), 64'(1));
            sb.delete(sb.size() - 1);
        end
        @(posedge PCLK);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        #1 PRESETn = 1'b0;
        #1;
        check("reset_req_ready",   64'(req_ready), 64'(1));
        check("reset_rsp_valid",   64'(rsp_valid), 64'(0));
        check("reset_psel",        64'(apb.PSEL), 64'(0));
        check("reset_penable",     64'(apb.PENABLE), 64'(0));
        check("reset_rsp_err",     64'(rsp_err), 64'(0));
        check("reset_rsp_timeout", 64'(rsp_timeout), 64'(0));
        check("reset_rsp_rdata",   64'(rsp_rdata), 64'(0));
        check("reset_paddr",       64'(apb.PADDR), 64'(0));
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;

        //     wr    addr               wdata         wt err hang exp_rd        e_err e_to lat keep
        issue(1'b1, GPIO_DIR,          32'hA5A5_0000, 0, 0, 0, 32'h0,         0, 0, 3,  0);
        issue(1'b0, GPIO_DIR,          32'hFFFF_FFFF, 0, 0, 0, 32'hA5A5_0000, 0, 0, 3,  0);
        issue(1'b1, GPIO_IN,           32'h0000_00F0, 0, 0, 0, 32'h0,         0, 0, 3,  0);
        issue(1'b0, GPIO_IN,           32'h0,         3, 0, 0, 32'h0000_00F0, 0, 0, 6,  0);
        issue(1'b1, GPIO_DEBOUNCE_CFG, 32'h1234_5678, 0, 1, 0, 32'h0,         1, 0, 3,  0);
        issue(1'b0, GPIO_OUT,          32'h0,         0, 0, 1, 32'h0,         1, 1, 18, 0);
        issue(1'b1, GPIO_INT_MASK,     32'h0000_00FF, 0, 0, 0, 32'h0,         0, 0, 3,  0);
        issue(1'b0, GPIO_INT_MASK,     32'h0,        15, 0, 0, 32'h0000_00FF, 0, 0, 18, 0);

        // Response stalled 10 cycles with the next request already waiting.
        @(posedge PCLK);
        #1 rsp_ready = 1'b0;
        fork
            begin
                int k;
                k = 0;
                do begin
                    @(posedge PCLK);
                    #1;
                    k++;
                end while (!rsp_valid && k < 500);
                repeat (10) @(posedge PCLK);
                #1 rsp_ready = 1'b1;
            end
        join_none
        issue(1'b1, GPIO_INT_STATUS, 32'h0000_0003, 0, 0, 0, 32'h0, 0, 0, 3, 1);
        expect_b2b = 1'b1;
        issue(1'b0, GPIO_INT_STATUS, 32'h0,         0, 0, 0, 32'h0000_0003, 0, 0, 3, 0);

        // Reset asserted while the slave holds the transfer in ACCESS.
        issue(1'b0, GPIO_INT_TYPE, 32'h0, 0, 0, 1, 32'h0, 0, 0, 3, 0);
        repeat (3) @(posedge PCLK);
        #2 PRESETn = 1'b0;
        #1;
        check("rst_mid_psel",      64'(apb.PSEL), 64'(0));
        check("rst_mid_penable",   64'(apb.PENABLE), 64'(0));
        check("rst_mid_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_mid_req_ready", 64'(req_ready), 64'(1));
        sb.delete(sb.size() - 1);
        s_hang = 1'b0;
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        issue(1'b0, GPIO_DIR, 32'h0, 0, 0, 0, 32'hA5A5_0000, 0, 0, 3, 0);

        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(posedge PCLK);
            n++;
        end
        check("drain", 64'(sb.size()), 64'(0));
        repeat (2) @(posedge PCLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
        $fatal(1, "watchdog");
    end

endmodule
